astar_grid_arbiter: RTL

Shares the single-port 10x10 grid memory (per-cell cost/parent/visited word) among the four A* engines: init, update, move and backtrace. Grants one access per cycle using round-robin with an optional lock for read-modify-write sequences. Translates (row, col) to a linear address and rejects out-of-grid coordinates. Sits between the engine datapaths and the grid RAM, under the A* state-machine controller.

---
 rtl/astar_grid_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/astar_grid_arbiter.sv
// Round-robin arbiter sharing the single-port A* grid RAM among the init, update,
// move and backtrace engines, with lock support and out-of-grid rejection.
module astar_grid_arbiter #(
  parameter int DATA_W    = 8,
  parameter int GRID_ROWS = 10,
  parameter int GRID_COLS = 10,
  parameter int ADDR_W    = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          req,
  input  logic [3:0]          we,
  input  logic [3:0]          lock,
  input  logic [15:0]         row_i,
  input  logic [15:0]         col_i,
  input  logic [4*DATA_W-1:0] wdata_i,
  output logic [3:0]          gnt,
  output logic [3:0]          rvalid,
  output logic [3:0]          err,
  output logic [DATA_W-1:0]   rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  logic [1:0]        last;
  logic              lock_valid;
  logic [1:0]        lock_idx;
  logic              pipe_rd;
  logic              pipe_err;
  logic [1:0]        pipe_idx;

  logic              gnt_any;
  logic [1:0]        gnt_idx;
  logic [1:0]        cand;
  logic [3:0]        sel_row;
  logic [3:0]        sel_col;
  logic              sel_we;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_range;

  // Lock holder wins while it keeps requesting; otherwise rotate starting after last.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    cand    = 2'd0;
    if (!rst) begin
      if (lock_valid && req[lock_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = lock_idx;
      end else begin
        for (int k = 1; k <= 4; k++) begin
          cand = last + 2'(k);
          if (!gnt_any && req[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
          end
        end
      end
    end
  end

  assign gnt       = gnt_any ? (4'b0001 << gnt_idx) : 4'b0000;
  assign sel_row   = row_i[gnt_idx*4 +: 4];
  assign sel_col   = col_i[gnt_idx*4 +: 4];
  assign sel_we    = we[gnt_idx];
  assign sel_wdata = wdata_i[gnt_idx*DATA_W +: DATA_W];
  assign in_range  = (sel_row < 4'(GRID_ROWS)) && (sel_col < 4'(GRID_COLS));

  // Out-of-grid grants are consumed but never reach the RAM.
  always_comb begin
    mem_en    = gnt_any && in_range;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_en) begin
      mem_we    = sel_we;
      mem_addr  = ADDR_W'(sel_row) * ADDR_W'(GRID_COLS) + ADDR_W'(sel_col);
      mem_wdata = sel_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last       <= 2'd3;
      lock_valid <= 1'b0;
      lock_idx   <= 2'd0;
      pipe_rd    <= 1'b0;
      pipe_err   <= 1'b0;
      pipe_idx   <= 2'd0;
    end else begin
      if (gnt_any) begin
        last       <= gnt_idx;
        lock_valid <= lock[gnt_idx];
        lock_idx   <= gnt_idx;
      end else if (lock_valid && !req[lock_idx]) begin
        lock_valid <= 1'b0;
      end
      pipe_rd  <= gnt_any && !sel_we;
      pipe_err <= gnt_any && !in_range;
      pipe_idx <= gnt_idx;
    end
  end

  // Rejected reads return zero; the RAM output is only passed through for real reads.
  assign rvalid = pipe_rd  ? (4'b0001 << pipe_idx) : 4'b0000;
  assign err    = pipe_err ? (4'b0001 << pipe_idx) : 4'b0000;
  assign rdata  = (pipe_rd && !pipe_err) ? mem_rdata : '0;

endmodule
